// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: FSM states, opcode
// classes and the ALUOp / ALUSrcB codes also consumed by the ALU control block.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_LD  = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  // R-type family 1x_x01_01x_000 covers ADD, SUB, AND and ORR.
  localparam logic [10:0] OP_R_MASK    = 11'b100_1111_0111;
  localparam logic [10:0] OP_R_MATCH   = 11'b100_0101_0000;
  localparam logic [10:0] OP_LDUR      = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR      = 11'b111_1100_0000;
  localparam logic [10:0] OP_CBZ_MASK  = 11'b111_1111_1000;
  localparam logic [10:0] OP_CBZ_MATCH = 11'b101_1010_0000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;

  typedef struct packed {
    logic is_r;
    logic is_ldur;
    logic is_stur;
    logic is_cbz;
    logic illegal;
  } op_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ior_d;
    logic       ir_write;
    logic       reg2loc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } strobes_t;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] mask,
                                    input logic [10:0] match);
    return (op & mask) == match;
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational classifier of the 11-bit LEGv8 opcode field into the
// instruction classes the sequencer dispatches on.
module opcode_class_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   cls
);

  always_comb begin
    cls         = '0;
    cls.is_r    = op_match(opcode, OP_R_MASK, OP_R_MATCH);
    cls.is_ldur = (opcode == OP_LDUR);
    cls.is_stur = (opcode == OP_STUR);
    cls.is_cbz  = op_match(opcode, OP_CBZ_MASK, OP_CBZ_MATCH);
    cls.illegal = !(cls.is_r || cls.is_ldur || cls.is_stur || cls.is_cbz);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control sequencer: fetch/decode/execute/memory/write-back
// FSM with a bounded wait on the unified memory handshake.
module multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IorD,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             halt,
  output logic             bus_err,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retire_count
);

  // The last wait cycle allowed is MEM_TIMEOUT-1 counted from zero.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             halt_q, halt_d;
  logic             bus_err_q, bus_err_d;
  logic             retire;
  logic             in_mem_state;
  logic             timeout;
  op_class_t        cls;
  strobes_t         st;

  opcode_class_decode u_decode (
    .opcode (opcode),
    .cls    (cls)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    halt_d    = halt_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;

    in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                   (state_q == S_MEM_WR);
    timeout      = in_mem_state && !mem_ready && (wait_q == WAIT_LAST);

    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (cls.is_r)                       state_d = S_EXEC_R;
        else if (cls.is_ldur || cls.is_stur) state_d = S_ADDR;
        else if (cls.is_cbz)                state_d = S_BRANCH;
        else begin
          state_d = S_HALT;
          halt_d  = 1'b1;
        end
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDR:   state_d = cls.is_stur ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
      S_WB_LD: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        halt_d  = 1'b1;
      end
    endcase

    if (timeout) begin
      state_d   = S_HALT;
      halt_d    = 1'b1;
      bus_err_d = 1'b1;
    end

    // Fresh wait budget on every entry into a memory-waiting state.
    if ((state_d != state_q) &&
        ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR)))
      wait_d = 8'd0;
    else if (in_mem_state && !mem_ready && !timeout)
      wait_d = wait_q + 8'd1;

    retire_d = retire_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      retire_q  <= '0;
      halt_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retire_q  <= retire_d;
      halt_q    <= halt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    st = '0;
    case (state_q)
      S_FETCH: begin
        st.mem_read  = 1'b1;
        st.alu_src_b = SRCB_FOUR;
        st.alu_op    = ALUOP_ADD;
        st.ir_write  = mem_ready;
        st.pc_write  = mem_ready;
      end
      S_DECODE: begin
        st.alu_src_b = SRCB_SEXT;
        st.alu_op    = ALUOP_ADD;
        st.reg2loc   = cls.is_stur || cls.is_cbz;
      end
      S_EXEC_R: begin
        st.alu_src_a = 1'b1;
        st.alu_src_b = SRCB_REG;
        st.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        st.reg_write = 1'b1;
        st.alu_op    = ALUOP_FUNCT;
      end
      S_ADDR: begin
        st.alu_src_a = 1'b1;
        st.alu_src_b = SRCB_SEXT;
        st.alu_op    = ALUOP_ADD;
        st.reg2loc   = 1'b1;
      end
      S_MEM_RD: begin
        st.mem_read = 1'b1;
        st.ior_d    = 1'b1;
      end
      S_WB_LD: begin
        st.reg_write  = 1'b1;
        st.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        st.mem_write = 1'b1;
        st.ior_d     = 1'b1;
        st.reg2loc   = 1'b1;
      end
      S_BRANCH: begin
        st.reg2loc   = 1'b1;
        st.alu_src_a = 1'b1;
        st.alu_src_b = SRCB_REG;
        st.alu_op    = ALUOP_PASSB;
        st.pc_write  = zero;
        st.pc_src    = zero;
      end
      default: st = '0;
    endcase
    if (reset) st = '0;
  end

  assign PCWrite      = st.pc_write;
  assign PCSrc        = st.pc_src;
  assign IorD         = st.ior_d;
  assign IRWrite      = st.ir_write;
  assign Reg2Loc      = st.reg2loc;
  assign MemRead      = st.mem_read;
  assign MemWrite     = st.mem_write;
  assign MemtoReg     = st.mem_to_reg;
  assign RegWrite     = st.reg_write;
  assign ALUSrcA      = st.alu_src_a;
  assign ALUSrcB      = st.alu_src_b;
  assign ALUOp        = st.alu_op;
  assign halt         = halt_q;
  assign bus_err      = bus_err_q;
  assign state_dbg    = state_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench: each stimulus cycle queues its expected state and
// strobes; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;

  localparam int TO = 4;
  localparam int CW = 3;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, EX = 4'd2, WR = 4'd3, AD = 4'd4;
  localparam logic [3:0] MR = 4'd5, WL = 4'd6, MW = 4'd7, BR = 4'd8, HT = 4'd9;

  // {PCWrite,PCSrc,IorD,IRWrite,Reg2Loc,MemRead,MemWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [13:0] SB_NONE  = 14'h0000;
  localparam logic [13:0] SB_FWAIT = 14'h0104;
  localparam logic [13:0] SB_FRDY  = 14'h2504;
  localparam logic [13:0] SB_DEC   = 14'h0008;
  localparam logic [13:0] SB_DECR2 = 14'h0208;
  localparam logic [13:0] SB_EXR   = 14'h0012;
  localparam logic [13:0] SB_WBR   = 14'h0022;
  localparam logic [13:0] SB_ADDR  = 14'h0218;
  localparam logic [13:0] SB_MRD   = 14'h0900;
  localparam logic [13:0] SB_WBLD  = 14'h0060;
  localparam logic [13:0] SB_MWR   = 14'h0A80;
  localparam logic [13:0] SB_BR0   = 14'h0211;
  localparam logic [13:0] SB_BR1   = 14'h3211;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_ILL  = 11'b00000000000;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ready;
  logic [10:0]   opcode;
  logic          PCWrite, PCSrc, IorD, IRWrite, Reg2Loc, MemRead, MemWrite;
  logic          MemtoReg, RegWrite, ALUSrcA, halt, bus_err;
  logic [1:0]    ALUSrcB, ALUOp;
  logic [3:0]    state_dbg;
  logic [CW-1:0] retire_count;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [13:0] sb;
    logic        hlt;
    logic        berr;
    logic [2:0]  ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [2:0] exp_ret  = 3'd0;
  logic       exp_halt = 1'b0;
  logic       exp_berr = 1'b0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite),
    .Reg2Loc(Reg2Loc), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .halt(halt), .bus_err(bus_err), .state_dbg(state_dbg), .retire_count(retire_count)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] sb;
      e  = exp_q.pop_front();
      sb = {PCWrite, PCSrc, IorD, IRWrite, Reg2Loc, MemRead, MemWrite, MemtoReg,
            RegWrite, ALUSrcA, ALUSrcB, ALUOp};
      checks++;
      if ({state_dbg, sb, halt, bus_err, retire_count} !==
          {e.st, e.sb, e.hlt, e.berr, e.ret}) begin
        errors++;
        $display("FAIL %s: got state=%0d strobes=%h halt=%b bus_err=%b retire=%0d, want state=%0d strobes=%h halt=%b bus_err=%b retire=%0d",
                 e.name, state_dbg, sb, halt, bus_err, retire_count,
                 e.st, e.sb, e.hlt, e.berr, e.ret);
      end else begin
        $display("chk %s ok state=%0d strobes=%h retire=%0d", e.name, state_dbg, sb, retire_count);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic rdy, input logic z,
                      input logic [3:0] st, input logic [13:0] sb);
    exp_t e;
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    e.name = nm; e.st = st; e.sb = sb;
    e.hlt = exp_halt; e.berr = exp_berr; e.ret = exp_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = OP_ADD;
    @(posedge clk);
    #1;
    step("reset_hold2", 1'b1, 1'b1, 1'b0, FE, SB_NONE);
    step("reset_hold3", 1'b1, 1'b1, 1'b0, FE, SB_NONE);

    opcode = OP_ADD;
    step("add_fetch",  1'b0, 1'b1, 1'b0, FE, SB_FRDY);
    step("add_decode", 1'b0, 1'b0, 1'b0, DE, SB_DEC);
    step("add_exec",   1'b0, 1'b1, 1'b0, EX, SB_EXR);
    step("add_wb",     1'b0, 1'b1, 1'b0, WR, SB_WBR);
    exp_ret++;

    opcode = OP_LDUR;
    step("ldur_fetch",  1'b0, 1'b1, 1'b0, FE, SB_FRDY);
    step("ldur_decode", 1'b0, 1'b1, 1'b0, DE, SB_DEC);
    step("ldur_addr",   1'b0, 1'b1, 1'b0, AD, SB_ADDR);
    for (int i = 0; i < 3; i++)
      step($sformatf("ldur_memwait%0d", i), 1'b0, 1'b0, 1'b0, MR, SB_MRD);
    step("ldur_memrdy", 1'b0, 1'b1, 1'b0, MR, SB_MRD);
    step("ldur_wb",     1'b0, 1'b1, 1'b0, WL, SB_WBLD);
    exp_ret++;

    opcode = OP_CBZ;
    step("cbz1_fetch",  1'b0, 1'b1, 1'b1, FE, SB_FRDY);
    step("cbz1_decode", 1'b0, 1'b1, 1'b1, DE, SB_DECR2);
    step("cbz1_taken",  1'b0, 1'b1, 1'b1, BR, SB_BR1);
    exp_ret++;
    step("cbz0_fetch",  1'b0, 1'b1, 1'b0, FE, SB_FRDY);
    step("cbz0_decode", 1'b0, 1'b1, 1'b0, DE, SB_DECR2);
    step("cbz0_fall",   1'b0, 1'b1, 1'b0, BR, SB_BR0);
    exp_ret++;

    opcode = OP_STUR;
    step("stur_fwait",  1'b0, 1'b0, 1'b0, FE, SB_FWAIT);
    step("stur_fetch",  1'b0, 1'b1, 1'b0, FE, SB_FRDY);
    step("stur_decode", 1'b0, 1'b0, 1'b0, DE, SB_DECR2);
    step("stur_addr",   1'b0, 1'b0, 1'b0, AD, SB_ADDR);
    step("stur_mem",    1'b0, 1'b1, 1'b0, MW, SB_MWR);
    exp_ret++;

    // Three more branches push the 3-bit retire counter through its wrap.
    opcode = OP_CBZ;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("wrap%0d_fetch", i),  1'b0, 1'b1, 1'b0, FE, SB_FRDY);
      step($sformatf("wrap%0d_decode", i), 1'b0, 1'b1, 1'b0, DE, SB_DECR2);
      step($sformatf("wrap%0d_branch", i), 1'b0, 1'b1, 1'b0, BR, SB_BR0);
      exp_ret++;
    end

    opcode = OP_ILL;
    step("ill_fetch",  1'b0, 1'b1, 1'b0, FE, SB_FRDY);
    step("ill_decode", 1'b0, 1'b1, 1'b0, DE, SB_DEC);
    exp_halt = 1'b1;
    for (int i = 0; i < 20; i++)
      step($sformatf("ill_halt%0d", i), 1'b0, 1'b1, i[0], HT, SB_NONE);
    step("ill_reset", 1'b1, 1'b1, 1'b0, HT, SB_NONE);
    exp_halt = 1'b0;
    exp_ret  = 3'd0;

    opcode = OP_SUB;
    for (int i = 0; i < TO; i++)
      step($sformatf("to_fwait%0d", i), 1'b0, 1'b0, 1'b0, FE, SB_FWAIT);
    exp_halt = 1'b1;
    exp_berr = 1'b1;
    step("to_halt0", 1'b0, 1'b1, 1'b0, HT, SB_NONE);
    step("to_halt1", 1'b0, 1'b1, 1'b0, HT, SB_NONE);
    step("to_reset", 1'b1, 1'b0, 1'b0, HT, SB_NONE);
    exp_halt = 1'b0;
    exp_berr = 1'b0;

    for (int i = 0; i < TO - 1; i++)
      step($sformatf("edge_fwait%0d", i), 1'b0, 1'b0, 1'b0, FE, SB_FWAIT);
    step("edge_lastrdy", 1'b0, 1'b1, 1'b0, FE, SB_FRDY);
    step("edge_decode",  1'b0, 1'b0, 1'b0, DE, SB_DEC);
    step("edge_exec",    1'b0, 1'b0, 1'b0, EX, SB_EXR);
    step("edge_wb",      1'b0, 1'b0, 1'b0, WR, SB_WBR);
    exp_ret++;

    opcode = OP_LDUR;
    step("rdto_fetch",  1'b0, 1'b1, 1'b0, FE, SB_FRDY);
    step("rdto_decode", 1'b0, 1'b1, 1'b0, DE, SB_DEC);
    step("rdto_addr",   1'b0, 1'b1, 1'b0, AD, SB_ADDR);
    for (int i = 0; i < TO; i++)
      step($sformatf("rdto_wait%0d", i), 1'b0, 1'b0, 1'b0, MR, SB_MRD);
    exp_halt = 1'b1;
    exp_berr = 1'b1;
    step("rdto_halt", 1'b0, 1'b1, 1'b0, HT, SB_NONE);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the LEGv8 datapath: R-type (ADD/SUB/AND/ORR), LDUR, STUR, CBZ.
- A state machine steps fetch, decode, execute, memory and write-back, and drives every datapath strobe.
- Waits on a variable-latency unified memory via a request/ready handshake, with a timeout.
- Replaces single-cycle decode in the multi-cycle core. Sits between the instruction register opcode field and the datapath muxes, register file and memory port.

Parameters:
- MEM_TIMEOUT, 255: max cycles spent waiting for mem_ready in one memory state before bus error; must be 1..255.
- CNT_W, 32: width of retire_count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  11  IR[31:21], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  load PC
- PCSrc  out  1  0=ALU result, 1=ALUOut (branch target)
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- IRWrite  out  1  load IR and latch instruction PC
- Reg2Loc  out  1  read reg2 from Rt field
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemtoReg  out  1  write-back source: 1=MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=instruction PC, 1=reg A
- ALUSrcB  out  2  00=reg B, 01=const 4, 10=sign-extended offset
- ALUOp  out  2  00=add, 01=pass B, 10=funct
- halt  out  1  sticky; set on illegal opcode or bus error
- bus_err  out  1  sticky; set on memory timeout
- state_dbg  out  4  current state encoding
- retire_count  out  CNT_W  instructions completed

Behaviour:
- Reset: state=FETCH, wait counter=0, retire_count=0, halt=0, bus_err=0.
  - While reset is high, all strobes are 0.
  - Reset dominates mem_ready.
  - Reset mid-operation abandons the instruction. No PC, register or memory write occurs in the reset cycle.
- Strobes are Moore-decoded from state, except where qualified below. Default for every strobe is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - On mem_ready, IRWrite=1 and PCWrite=1 (PCSrc=0) in that same cycle, then go to DECODE. Otherwise stay.
- DECODE (1 cycle):
  - Drives ALUSrcA=0, ALUSrcB=10, ALUOp=00 to compute the branch target into ALUOut.
  - Drives Reg2Loc=1 when the opcode is STUR or CBZ.
  - Dispatch:
    - R-type (1x_x01_01x_000) -> EXEC_R
    - 11111000010 (LDUR) or 11111000000 (STUR) -> ADDR
    - 10110100xxx (CBZ) -> BRANCH
    - anything else -> HALT
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R.
- WB_R: RegWrite=1, MemtoReg=0, ALUOp=10 held -> FETCH; retire.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=1 -> MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: MemRead=1, IorD=1; on mem_ready -> WB_LD.
- WB_LD: RegWrite=1, MemtoReg=1 -> FETCH; retire.
- MEM_WR: MemWrite=1, IorD=1, Reg2Loc=1; on mem_ready -> FETCH; retire.
- BRANCH:
  - Drives Reg2Loc=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01.
  - If zero=1: PCWrite=1, PCSrc=1.
  - Always -> FETCH; retire.
- HALT: absorbing until reset. halt=1, all strobes 0, retire_count frozen.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR. Increments each cycle that mem_ready=0 in those states.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: -> HALT, bus_err=1.
  - mem_ready in the cycle the counter hits MEM_TIMEOUT counts as success.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Retire: retire_count increments by 1 on each transition into FETCH from a completion state. It wraps at 2^CNT_W - 1 -> 0.
- Latency with mem_ready tied high:
  - R-type: 4 cycles
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - CBZ: 3 cycles
  - Each memory wait cycle adds 1.

Decomposition:
- Shared package legv8_ctrl_pkg holds:
  - state encodings (4-bit)
  - opcode match constants/masks for R-type, LDUR, STUR, CBZ
  - ALUOp and ALUSrcB encodings, shared with the ALU control block
- Natural sub-module: opcode_class_decode, a combinational 11-bit opcode -> {is_r, is_ldur, is_stur, is_cbz, illegal}, reusable by the single-cycle core.

Test Plan:
- reset held 3 cycles, then released with mem_ready=1 -> state_dbg=FETCH; all strobes 0 during reset; retire_count=0.
- ADD (opcode 10001011000), mem_ready=1 -> FETCH, DECODE, EXEC_R, WB_R; RegWrite=1 only in cycle 4; retire_count=1.
- LDUR (11111000010), mem_ready delayed 3 cycles in MEM_RD -> MemRead held 4 cycles with IorD=1; WB_LD asserts RegWrite=1 and MemtoReg=1; total 8 cycles.
- CBZ (10110100101), zero=1 then zero=0 -> PCWrite=1 with PCSrc=1 in BRANCH for zero=1; PCWrite=0 for zero=0; both retire.
- Illegal opcode 00000000000 -> HALT after DECODE; halt=1; strobes 0 for 20 cycles; reset returns the block to FETCH.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles with bus_err=1; repeat with mem_ready on the 4th cycle -> DECODE, no error.
